// File: rtl/hammer_multi.sv
// Whack-a-mole hit detector: synchronises board switches, scores rising edges against
// up to NUM_MOLES mole slots and keeps saturating hit/miss counters and streaks.
module hammer_multi #(
   parameter int unsigned NUM_SWITCHES = 18,
   parameter int unsigned NUM_MOLES    = 2,
   parameter int unsigned POS_W        = 5,
   parameter int unsigned COUNT_W      = 12,
   parameter int unsigned STREAK_W     = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         clear,
   input  logic [NUM_SWITCHES-1:0]      switches,
   input  logic [NUM_MOLES*POS_W-1:0]   mole_positions,
   input  logic [NUM_MOLES-1:0]         mole_valid,
   output logic                         hit,
   output logic [NUM_MOLES-1:0]         hit_mask,
   output logic                         miss,
   output logic [COUNT_W-1:0]           hit_count,
   output logic [COUNT_W-1:0]           miss_count,
   output logic [STREAK_W-1:0]          streak,
   output logic [STREAK_W-1:0]          best_streak
);

   localparam int unsigned PC_W  = $clog2(NUM_MOLES + 1);
   localparam int unsigned HC_W  = COUNT_W + 1;
   localparam int unsigned STS_W = STREAK_W + 1;

   logic [NUM_SWITCHES-1:0]           s1, s2, prev;
   logic [NUM_SWITCHES-1:0]           rise_c, covered_c;
   logic [NUM_MOLES-1:0][POS_W-1:0]   pos_c, pos_q;
   logic [NUM_MOLES-1:0]              whacked, whacked_c;
   logic [NUM_MOLES-1:0]              hittable_c, hit_mask_c;
   logic                              miss_c;
   logic [PC_W-1:0]                   pc_c;
   logic [HC_W-1:0]                   hc_sum_c, mc_sum_c;
   logic [STS_W-1:0]                  st_sum_c;
   logic [COUNT_W-1:0]                hit_count_c, miss_count_c;
   logic [STREAK_W-1:0]               streak_c, best_c;

   assign pos_c  = mole_positions;
   assign rise_c = s2 & ~prev;

   // Hit/miss decode and next-state for whacked flags, counters and streaks
   always_comb begin
      covered_c  = '0;
      hittable_c = '0;
      hit_mask_c = '0;
      whacked_c  = '0;
      pc_c       = '0;
      for (int unsigned i = 0; i < NUM_MOLES; i++) begin
         logic sel;
         logic moved;
         sel           = 1'b0;
         hittable_c[i] = mole_valid[i] & ~whacked[i] & (32'(pos_c[i]) < NUM_SWITCHES);
         for (int unsigned j = 0; j < NUM_SWITCHES; j++) begin
            if (32'(pos_c[i]) == j) begin
               sel          = sel | rise_c[j];
               covered_c[j] = covered_c[j] | hittable_c[i];
            end
         end
         hit_mask_c[i] = enable & hittable_c[i] & sel;
         pc_c          = pc_c + PC_W'(hit_mask_c[i]);
         // A mole that went down or moved is a fresh target
         moved         = ~mole_valid[i] | (pos_c[i] != pos_q[i]);
         whacked_c[i]  = hit_mask_c[i] | (whacked[i] & ~moved);
      end
      miss_c = enable & (|(rise_c & ~covered_c));

      hc_sum_c    = {1'b0, hit_count} + HC_W'(pc_c);
      hit_count_c = hc_sum_c[COUNT_W] ? '1 : hc_sum_c[COUNT_W-1:0];
      mc_sum_c    = {1'b0, miss_count} + HC_W'(miss_c);
      miss_count_c = mc_sum_c[COUNT_W] ? '1 : mc_sum_c[COUNT_W-1:0];

      st_sum_c = {1'b0, streak} + STS_W'(pc_c);
      if (miss_c)
         streak_c = '0;
      else
         streak_c = st_sum_c[STREAK_W] ? '1 : st_sum_c[STREAK_W-1:0];
      best_c = (streak_c > best_streak) ? streak_c : best_streak;
   end

   // Synchroniser and edge-detect history; never affected by clear or enable
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1    <= '0;
         s2    <= '0;
         prev  <= '0;
         pos_q <= '0;
      end else begin
         s1    <= switches;
         s2    <= s1;
         prev  <= s2;
         pos_q <= pos_c;
      end
   end

   // Scoring state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         whacked     <= '0;
         hit         <= 1'b0;
         hit_mask    <= '0;
         miss        <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
         streak      <= '0;
         best_streak <= '0;
      end else if (clear) begin
         whacked     <= '0;
         hit         <= 1'b0;
         hit_mask    <= '0;
         miss        <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
         streak      <= '0;
         best_streak <= '0;
      end else begin
         whacked     <= whacked_c;
         hit         <= |hit_mask_c;
         hit_mask    <= hit_mask_c;
         miss        <= miss_c;
         hit_count   <= hit_count_c;
         miss_count  <= miss_count_c;
         streak      <= streak_c;
         best_streak <= best_c;
      end
   end

endmodule
